// File: rtl/signed_result_bcd_pkg.sv
// -----------------------------------------------------------------------------
// signed_result_bcd_pkg
// Shared definitions for the signed quotient/remainder to BCD converter:
//   - FSM state encodings
//   - default operand width and BCD digit count
//   - the shift-add-3 threshold and the per-digit correction helper
// -----------------------------------------------------------------------------
package signed_result_bcd_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    // Default operand width and digits per result (10^DIGITS > 2^(WIDTH-1))
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGITS = 3;

    // A digit at or above this value would exceed 9 after doubling
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // Pre-shift correction of one BCD digit
    function automatic logic [3:0] add3_digit(input logic [3:0] digit);
        logic [3:0] result;
        if (digit >= ADD3_THRESH) begin
            result = digit + 4'd3;
        end else begin
            result = digit;
        end
        return result;
    endfunction

endpackage : signed_result_bcd_pkg

// File: rtl/bcd_dabble_step.sv
// -----------------------------------------------------------------------------
// bcd_dabble_step
// One combinational double-dabble iteration: every BCD digit >= 5 gets +3,
// then the concatenation {bcd, mag} is shifted left by one bit.
// Ports:
//   bcd     in   4*DIGITS        current BCD accumulator, digit 0 in [3:0]
//   mag     in   WIDTH           remaining binary magnitude bits
//   shifted out  4*DIGITS+WIDTH  {bcd_adjusted, mag} << 1
// -----------------------------------------------------------------------------
module bcd_dabble_step
    import signed_result_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic [4*DIGITS-1:0]       bcd,
    input  logic [WIDTH-1:0]          mag,
    output logic [4*DIGITS+WIDTH-1:0] shifted
);

    logic [4*DIGITS-1:0] adj_s;

    // Correct each digit, then shift the MSB of the magnitude into digit 0
    always_comb begin
        adj_s = {(4*DIGITS){1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            adj_s[4*i +: 4] = add3_digit(bcd[4*i +: 4]);
        end
        // The top bit of the adjusted accumulator is always zero for legal
        // DIGITS/WIDTH combinations, so dropping it loses nothing.
        shifted = {adj_s[4*DIGITS-2:0], mag, 1'b0};
    end

endmodule : bcd_dabble_step

// File: rtl/signed_result_bcd_converter.sv
// -----------------------------------------------------------------------------
// signed_result_bcd_converter
// Converts the signed divider quotient and remainder into sign-magnitude BCD
// using sequential double dabble, one bit per clock, both operands in parallel.
// Ports:
//   clk        in   1         system clock, rising edge
//   rst        in   1         synchronous active-high reset
//   start_sig  in   1         request, held until done_sig is seen
//   quotient   in   WIDTH     signed quotient, sampled on the accept edge
//   reminder   in   WIDTH     signed remainder, sampled on the accept edge
//   done_sig   out  1         one-cycle completion pulse
//   q_sign     out  1         quotient negative
//   q_bcd      out  4*DIGITS  quotient magnitude in BCD
//   r_sign     out  1         remainder negative
//   r_bcd      out  4*DIGITS  remainder magnitude in BCD
// -----------------------------------------------------------------------------
module signed_result_bcd_converter
    import signed_result_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_sig,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      reminder,
    output logic                  done_sig,
    output logic                  q_sign,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic                  r_sign,
    output logic [4*DIGITS-1:0]   r_bcd
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int SW = 4*DIGITS + WIDTH;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CW-1:0]       cnt_r;
    logic [WIDTH-1:0]    q_mag_r;
    logic [WIDTH-1:0]    r_mag_r;
    logic [4*DIGITS-1:0] q_acc_r;
    logic [4*DIGITS-1:0] r_acc_r;
    logic                q_sign_cap_r;
    logic                r_sign_cap_r;
    logic [SW-1:0]       q_step_s;
    logic [SW-1:0]       r_step_s;
    logic                load_s;
    logic                shift_s;
    logic                finish_s;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1)
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] m;
        if (x[WIDTH-1]) begin
            m = ~x + WIDTH'(1);
        end else begin
            m = x;
        end
        return m;
    endfunction

    bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_q_step (
        .bcd     (q_acc_r),
        .mag     (q_mag_r),
        .shifted (q_step_s)
    );

    bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_r_step (
        .bcd     (r_acc_r),
        .mag     (r_mag_r),
        .shifted (r_step_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; WAIT_LOW keeps a level-held start from retriggering
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_sig) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (start_sig) begin
                    state_nxt_s = WAIT_LOW;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_LOW: begin
                if (start_sig) begin
                    state_nxt_s = WAIT_LOW;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath control decode from the current state
    always_comb begin
        load_s   = 1'b0;
        shift_s  = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                load_s = start_sig;
            end
            SHIFT: begin
                shift_s  = 1'b1;
                finish_s = (cnt_r == {CW{1'b0}});
            end
            DONE, WAIT_LOW: begin
                load_s = 1'b0;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Capture, shift and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= {CW{1'b0}};
            q_mag_r      <= {WIDTH{1'b0}};
            r_mag_r      <= {WIDTH{1'b0}};
            q_acc_r      <= {(4*DIGITS){1'b0}};
            r_acc_r      <= {(4*DIGITS){1'b0}};
            q_sign_cap_r <= 1'b0;
            r_sign_cap_r <= 1'b0;
            done_sig     <= 1'b0;
            q_sign       <= 1'b0;
            r_sign       <= 1'b0;
            q_bcd        <= {(4*DIGITS){1'b0}};
            r_bcd        <= {(4*DIGITS){1'b0}};
        end else begin
            if (load_s) begin
                q_sign_cap_r <= quotient[WIDTH-1];
                r_sign_cap_r <= reminder[WIDTH-1];
                q_mag_r      <= abs_mag(quotient);
                r_mag_r      <= abs_mag(reminder);
                q_acc_r      <= {(4*DIGITS){1'b0}};
                r_acc_r      <= {(4*DIGITS){1'b0}};
                cnt_r        <= CW'(WIDTH - 1);
            end else if (shift_s) begin
                q_acc_r <= q_step_s[SW-1:WIDTH];
                q_mag_r <= q_step_s[WIDTH-1:0];
                r_acc_r <= r_step_s[SW-1:WIDTH];
                r_mag_r <= r_step_s[WIDTH-1:0];
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_r <= cnt_r - CW'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end

            // Results publish on the last shift edge and hold until the next one
            done_sig <= finish_s;
            if (finish_s) begin
                q_sign <= q_sign_cap_r;
                r_sign <= r_sign_cap_r;
                q_bcd  <= q_step_s[SW-1:WIDTH];
                r_bcd  <= r_step_s[SW-1:WIDTH];
            end else begin
                q_sign <= q_sign;
                r_sign <= r_sign;
                q_bcd  <= q_bcd;
                r_bcd  <= r_bcd;
            end
        end
    end

endmodule : signed_result_bcd_converter

// File: doc/signed_result_bcd_converter.md
Name: signed_result_bcd_converter

Overview:
- Sits directly downstream of the 8-bit streamlined signed divider.
- Takes the divider's two's-complement quotient and remainder and converts each one into sign-magnitude BCD (sign bit plus 3 digits) for the display/UART formatting stage.
- Conversion is sequential shift-add-3 (double dabble), one bit per clock, with both operands processed in parallel.
- Uses the same start_sig/done_sig handshake as the divider.

Parameters:
- WIDTH, 8: operand width in bits for quotient and remainder.
- DIGITS, 3: BCD digits per result; must satisfy 10^DIGITS > 2^(WIDTH-1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_sig  input  1  held high by the master until done_sig is seen; master then drops it.
- quotient  input  WIDTH  signed two's-complement quotient; sampled only on the accept edge.
- reminder  input  WIDTH  signed two's-complement remainder; sampled only on the accept edge.
- done_sig  output  1  one-cycle pulse; results are valid from this cycle onward.
- q_sign  output  1  1 = quotient negative.
- q_bcd  output  4*DIGITS  quotient magnitude in BCD; digit 0 is in bits [3:0].
- r_sign  output  1  1 = remainder negative.
- r_bcd  output  4*DIGITS  remainder magnitude in BCD.

Behaviour:
- Reset (rst=1 at an edge): state goes to IDLE; done_sig, q_sign, r_sign, q_bcd and r_bcd all become 0; internal shift registers and the bit counter are cleared.
- Reset mid-operation: the conversion is abandoned; no done_sig is generated; the next conversion needs a fresh start_sig.
- States: IDLE, SHIFT, DONE, WAIT_LOW.
- IDLE, start_sig=0: stay in IDLE.
- IDLE, start_sig=1 (accept edge E):
  - Capture each sign as the operand MSB.
  - Capture magnitude = MSB ? (~x+1) : x, held as a WIDTH-bit unsigned value. -128 gives 128 with no overflow.
  - Clear the BCD accumulators, load the bit counter with WIDTH-1, go to SHIFT.
- SHIFT, at each edge and for each operand:
  - Add 3 to every BCD digit that is >= 5.
  - Shift {bcd, mag} left by one.
  - Decrement the counter.
  - When the counter is 0, this is the last shift: write the final BCD and the captured signs to the outputs, set done_sig=1, go to DONE. This happens at edge E+WIDTH (E+8 by default).
- DONE: at the next edge set done_sig=0. Go to WAIT_LOW if start_sig=1, else to IDLE.
- WAIT_LOW: stay until start_sig=0, then go to IDLE. A level-held start therefore never retriggers.
- Latency and pulse shape:
  - done_sig is high exactly during the cycle after edge E+WIDTH.
  - Minimum spacing between two accept edges is WIDTH+2 cycles.
- Output holding: outputs change only on the done edge or on reset, and hold between conversions.
- Input changes: quotient and reminder changes after E are ignored; so is a start_sig drop during SHIFT (the conversion completes).
- Zero input: sign 0, bcd 0x000. A negative input never yields a negative zero.

Decomposition:
- Package signed_result_bcd_pkg holds:
  - the state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2, WAIT_LOW=2'd3);
  - default WIDTH and DIGITS constants;
  - the constant ADD3_THRESH=4'd5.
- Sub-module bcd_dabble_step: combinational; input {bcd, mag}; output the add-3-then-shift-left result. Instantiated twice, once for the quotient and once for the remainder.

Test Plan:
- Reset, then q=8'd3, r=8'd1 (7/2), start high until done → exactly one done pulse 9 cycles after the accept edge; q_sign=0, q_bcd=12'h003, r_sign=0, r_bcd=12'h001.
- q=8'hFE, r=8'h02 (8/-3) → q_sign=1, q_bcd=12'h002, r_sign=0, r_bcd=12'h002.
- q=8'hFD, r=8'hFF (-19/6), then q=8'h11, r=8'hFF (-120/-7) back to back:
  - first result: q_sign=1, q_bcd=003, r_sign=1, r_bcd=001;
  - second result: q_sign=0, q_bcd=017, r_sign=1, r_bcd=001;
  - WAIT_LOW holds off the second conversion until start drops.
- Extremes: q=8'h80, r=8'h7F → q_sign=1, q_bcd=12'h128, r_sign=0, r_bcd=12'h127. Then q=8'h00, r=8'h00 → both signs 0, both bcd 12'h000.
- Start held high for 30 cycles → exactly one done pulse. Inputs changed mid-SHIFT → result reflects the values captured at accept.
- rst=1 at SHIFT cycle 4 → no done_sig; outputs 0 on the next edge. A subsequent start converts correctly.
